// File: rtl/muldiv_sched_if.sv
// Signal bundle between the E-stage multiply/divide scheduler, the pipeline,
// the pipelined multiplier and the iterative divider.
interface muldiv_sched_if;
    logic        op_mul_i;
    logic        op_div_i;
    logic        op_signed_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        stall_i;
    logic        flush_i;
    logic        mul_start_o;
    logic [63:0] mul_result_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic [31:0] opa_o;
    logic [31:0] opb_o;
    logic        signed_o;
    logic        stall_o;
    logic [63:0] result_o;
    logic        result_valid_o;
    logic        hilo_we_o;

    modport slave (
        input  op_mul_i,
        input  op_div_i,
        input  op_signed_i,
        input  src_a_i,
        input  src_b_i,
        input  stall_i,
        input  flush_i,
        input  mul_result_i,
        input  div_ready_i,
        input  div_result_i,
        output mul_start_o,
        output div_start_o,
        output div_annul_o,
        output opa_o,
        output opb_o,
        output signed_o,
        output stall_o,
        output result_o,
        output result_valid_o,
        output hilo_we_o
    );

    modport master (
        output op_mul_i,
        output op_div_i,
        output op_signed_i,
        output src_a_i,
        output src_b_i,
        output stall_i,
        output flush_i,
        output mul_result_i,
        output div_ready_i,
        output div_result_i,
        input  mul_start_o,
        input  div_start_o,
        input  div_annul_o,
        input  opa_o,
        input  opb_o,
        input  signed_o,
        input  stall_o,
        input  result_o,
        input  result_valid_o,
        input  hilo_we_o
    );
endinterface

// File: rtl/muldiv_sched.sv
// E-stage MULT/DIV scheduler: launches the multiplier or divider, stalls the
// pipeline while busy, and presents the {hi,lo} result for one HI/LO write.
module muldiv_sched #(
    parameter int unsigned MUL_LAT = 2
) (
    input logic           clk,
    input logic           rst,
    muldiv_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        MUL_BUSY,
        DIV_BUSY,
        DONE
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        signed_q, signed_d;
    logic [63:0] result_q, result_d;

    logic mul_start;
    logic div_start;
    logic div_annul;
    logic hilo_we;
    logic stall;
    logic valid;
    logic op_req;

    assign op_req = (bus.op_mul_i | bus.op_div_i) & ~bus.flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            signed_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            signed_q <= signed_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        signed_d  = signed_q;
        result_d  = result_q;
        mul_start = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;
        hilo_we   = 1'b0;
        stall     = 1'b0;
        valid     = 1'b0;
        unique case (state_q)
            IDLE: begin
                result_d = '0;
                stall    = op_req;
                if (op_req) begin
                    opa_d    = bus.src_a_i;
                    opb_d    = bus.src_b_i;
                    signed_d = bus.op_signed_i;
                    if (bus.op_div_i) begin
                        // Divide by zero never reaches the divider.
                        if (bus.src_b_i == '0) begin
                            result_d = {bus.src_a_i, 32'hFFFF_FFFF};
                            state_d  = DONE;
                        end else begin
                            div_start = 1'b1;
                            state_d   = DIV_BUSY;
                        end
                    end else begin
                        mul_start = 1'b1;
                        cnt_d     = CNT_INIT;
                        state_d   = MUL_BUSY;
                    end
                end
            end
            MUL_BUSY: begin
                stall = 1'b1;
                if (bus.flush_i) begin
                    result_d = '0;
                    state_d  = IDLE;
                end else if (cnt_q == '0) begin
                    result_d = bus.mul_result_i;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DIV_BUSY: begin
                stall = 1'b1;
                if (bus.flush_i) begin
                    div_annul = 1'b1;
                    result_d  = '0;
                    state_d   = IDLE;
                end else if (bus.div_ready_i) begin
                    result_d = bus.div_result_i;
                    state_d  = DONE;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (bus.flush_i) begin
                    result_d = '0;
                    state_d  = IDLE;
                end else if (!bus.stall_i) begin
                    hilo_we  = 1'b1;
                    result_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                result_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // Start pulses are decoded from live inputs, so mask them during reset.
    assign bus.mul_start_o    = mul_start & rst;
    assign bus.div_start_o    = div_start & rst;
    assign bus.div_annul_o    = div_annul;
    assign bus.hilo_we_o      = hilo_we;
    assign bus.result_valid_o = valid;
    assign bus.stall_o        = stall;
    assign bus.opa_o          = opa_q;
    assign bus.opb_o          = opb_q;
    assign bus.signed_o       = signed_q;
    assign bus.result_o       = result_q;
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: vector table of whole operations plus
// hand-written flush, DONE-stall and reset sequences.
module tb_muldiv_sched;
    localparam int ML = 2;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

    logic clk = 1'b0;
    logic rst = 1'b0;

    muldiv_sched_if mif ();

    muldiv_sched #(.MUL_LAT(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        mul;
        logic        div;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          dlat;
        logic [63:0] rsp;
        int          exp_lat;
        logic [63:0] exp_res;
        int          exp_ms;
        int          exp_ds;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(
        input logic mul, input logic div, input logic sgn,
        input logic [31:0] a, input logic [31:0] b, input int dlat,
        input logic [63:0] rsp, input int exp_lat,
        input logic [63:0] exp_res, input int exp_ms, input int exp_ds);
        vec_t v;
        v.mul = mul; v.div = div; v.sgn = sgn;
        v.a = a; v.b = b; v.dlat = dlat; v.rsp = rsp;
        v.exp_lat = exp_lat; v.exp_res = exp_res;
        v.exp_ms = exp_ms; v.exp_ds = exp_ds;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        mif.op_mul_i     = 1'b0;
        mif.op_div_i     = 1'b0;
        mif.op_signed_i  = 1'b0;
        mif.src_a_i      = '0;
        mif.src_b_i      = '0;
        mif.stall_i      = 1'b0;
        mif.flush_i      = 1'b0;
        mif.mul_result_i = JUNK;
        mif.div_ready_i  = 1'b0;
        mif.div_result_i = JUNK;
    endtask

    task automatic clear_op();
        mif.op_mul_i = 1'b0;
        mif.op_div_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat = -1;
        int ms = 0;
        int ds = 0;
        int st = 0;
        int we = 0;
        logic [63:0] res = '0;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        mif.op_mul_i    = v.mul;
        mif.op_div_i    = v.div;
        mif.op_signed_i = v.sgn;
        mif.src_a_i     = v.a;
        mif.src_b_i     = v.b;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) clear_op();
            mif.mul_result_i = (c == ML) ? v.rsp : JUNK;
            mif.div_ready_i  = v.div && (v.b != 0) && (c == v.dlat);
            mif.div_result_i = mif.div_ready_i ? v.rsp : JUNK;
            #1;
            ms += int'(mif.mul_start_o);
            ds += int'(mif.div_start_o);
            st += int'(mif.stall_o);
            if (c == 1) begin
                chk({p, " opa"}, 64'(mif.opa_o), 64'(v.a));
                chk({p, " opb"}, 64'(mif.opb_o), 64'(v.b));
                chk({p, " signed"}, 64'(mif.signed_o), 64'(v.sgn));
            end
            if (mif.result_valid_o) begin
                lat = c;
                res = mif.result_o;
                we  = int'(mif.hilo_we_o);
                break;
            end
        end
        mif.div_ready_i  = 1'b0;
        mif.mul_result_i = JUNK;
        chk({p, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({p, " result"}, res, v.exp_res);
        chk({p, " mul_start count"}, 64'(ms), 64'(v.exp_ms));
        chk({p, " div_start count"}, 64'(ds), 64'(v.exp_ds));
        chk({p, " stall cycles"}, 64'(st), 64'(v.exp_lat));
        chk({p, " hilo_we in done"}, 64'(we), 64'd1);
        @(negedge clk);
        #1;
        chk({p, " idle valid"}, 64'(mif.result_valid_o), 64'd0);
        chk({p, " idle hilo_we"}, 64'(mif.hilo_we_o), 64'd0);
        chk({p, " idle result"}, mif.result_o, 64'd0);
    endtask

    initial begin
        vecs[0] = mk(1, 0, 0, 32'hFFFF_FFFF, 32'd2, 0,
                     64'h1_FFFF_FFFE, ML + 1, 64'h0000_0001_FFFF_FFFE, 1, 0);
        vecs[1] = mk(1, 0, 1, 32'hFFFF_FFFD, 32'd5, 0,
                     64'hFFFF_FFFF_FFFF_FFF1, ML + 1,
                     64'hFFFF_FFFF_FFFF_FFF1, 1, 0);
        vecs[2] = mk(0, 1, 1, 32'hFFFF_FFF9, 32'd2, 33,
                     64'hFFFF_FFFF_FFFF_FFFD, 34,
                     64'hFFFF_FFFF_FFFF_FFFD, 0, 1);
        vecs[3] = mk(0, 1, 0, 32'd100, 32'd7, 5,
                     64'h0000_0002_0000_000E, 6,
                     64'h0000_0002_0000_000E, 0, 1);
        vecs[4] = mk(0, 1, 0, 32'd5, 32'd0, 0,
                     JUNK, 1, 64'h0000_0005_FFFF_FFFF, 0, 0);
        vecs[5] = mk(1, 1, 0, 32'd9, 32'd3, 4,
                     64'h0000_0000_0000_0003, 5,
                     64'h0000_0000_0000_0003, 0, 1);
        vecs[6] = mk(1, 1, 0, 32'h1234_5678, 32'd0, 0,
                     JUNK, 1, 64'h1234_5678_FFFF_FFFF, 0, 0);

        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall", 64'(mif.stall_o), 64'd0);
        chk("reset valid", 64'(mif.result_valid_o), 64'd0);
        chk("reset result", mif.result_o, 64'd0);
        chk("reset opa", 64'(mif.opa_o), 64'd0);
        mif.op_mul_i = 1'b1;
        #1;
        chk("reset stall follows idle", 64'(mif.stall_o), 64'd1);
        chk("reset mul_start masked", 64'(mif.mul_start_o), 64'd0);
        clear_op();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // DONE held by stall_i for three cycles
        begin
            int we = 0;
            @(negedge clk);
            mif.op_mul_i = 1'b1; mif.src_a_i = 32'd3; mif.src_b_i = 32'd4;
            mif.stall_i = 1'b1;
            @(negedge clk);
            clear_op();
            @(negedge clk);
            mif.mul_result_i = 64'hC;
            @(negedge clk);
            mif.mul_result_i = JUNK;
            for (int k = 0; k < 3; k++) begin
                if (k > 0) @(negedge clk);
                #1;
                chk($sformatf("stall done valid %0d", k),
                    64'(mif.result_valid_o), 64'd1);
                we += int'(mif.hilo_we_o);
            end
            chk("stall done hilo_we held", 64'(we), 64'd0);
            @(negedge clk);
            mif.stall_i = 1'b0;
            #1;
            chk("stall done hilo_we release", 64'(mif.hilo_we_o), 64'd1);
            chk("stall done result", mif.result_o, 64'hC);
            @(negedge clk);
            #1;
            chk("stall done back idle", 64'(mif.result_valid_o), 64'd0);
            chk("stall done single we", 64'(mif.hilo_we_o), 64'd0);
        end

        // flush on DIV_BUSY cycle 10 together with div_ready_i
        begin
            int bad = 0;
            @(negedge clk);
            mif.op_div_i = 1'b1; mif.src_a_i = 32'd100; mif.src_b_i = 32'd7;
            #1;
            chk("flush div start", 64'(mif.div_start_o), 64'd1);
            for (int c = 1; c < 10; c++) begin
                @(negedge clk);
                if (c == 1) clear_op();
                #1;
                bad += int'(mif.div_start_o) + int'(mif.div_annul_o);
            end
            chk("flush div no early pulses", 64'(bad), 64'd0);
            @(negedge clk);
            mif.flush_i = 1'b1;
            mif.div_ready_i = 1'b1;
            mif.div_result_i = 64'h2_0000_000E;
            #1;
            chk("flush div annul", 64'(mif.div_annul_o), 64'd1);
            chk("flush div we", 64'(mif.hilo_we_o), 64'd0);
            @(negedge clk);
            mif.flush_i = 1'b0;
            mif.div_ready_i = 1'b0;
            mif.div_result_i = JUNK;
            #1;
            chk("flush div annul single", 64'(mif.div_annul_o), 64'd0);
            chk("flush div stall", 64'(mif.stall_o), 64'd0);
            chk("flush div result", mif.result_o, 64'd0);
            bad = 0;
            for (int k = 0; k < 3; k++) begin
                if (k > 0) @(negedge clk);
                #1;
                bad += int'(mif.result_valid_o) + int'(mif.hilo_we_o);
            end
            chk("flush div no done", 64'(bad), 64'd0);
        end

        // flush in MUL_BUSY
        @(negedge clk);
        mif.op_mul_i = 1'b1; mif.src_a_i = 32'd6; mif.src_b_i = 32'd7;
        @(negedge clk);
        clear_op();
        mif.flush_i = 1'b1;
        #1;
        chk("flush mul no annul", 64'(mif.div_annul_o), 64'd0);
        @(negedge clk);
        mif.flush_i = 1'b0;
        mif.mul_result_i = 64'd42;
        #1;
        chk("flush mul stall", 64'(mif.stall_o), 64'd0);
        @(negedge clk);
        mif.mul_result_i = JUNK;
        #1;
        chk("flush mul no done", 64'(mif.result_valid_o), 64'd0);

        // flush in DONE
        @(negedge clk);
        mif.op_div_i = 1'b1; mif.src_a_i = 32'd8; mif.src_b_i = 32'd0;
        #1;
        chk("flush done no div_start", 64'(mif.div_start_o), 64'd0);
        @(negedge clk);
        clear_op();
        mif.flush_i = 1'b1;
        #1;
        chk("flush done valid", 64'(mif.result_valid_o), 64'd1);
        chk("flush done we", 64'(mif.hilo_we_o), 64'd0);
        @(negedge clk);
        mif.flush_i = 1'b0;
        #1;
        chk("flush done idle", 64'(mif.result_valid_o), 64'd0);
        chk("flush done idle we", 64'(mif.hilo_we_o), 64'd0);

        // asynchronous reset mid-MUL_BUSY
        @(negedge clk);
        mif.op_mul_i = 1'b1; mif.op_signed_i = 1'b1;
        mif.src_a_i = 32'hFFFF_0000; mif.src_b_i = 32'd3;
        @(negedge clk);
        clear_op();
        #1;
        chk("rst pre busy", 64'(mif.stall_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst async stall", 64'(mif.stall_o), 64'd0);
        chk("rst async opa", 64'(mif.opa_o), 64'd0);
        chk("rst async opb", 64'(mif.opb_o), 64'd0);
        chk("rst async signed", 64'(mif.signed_o), 64'd0);
        chk("rst async result", mif.result_o, 64'd0);
        chk("rst async pulses",
            64'({mif.mul_start_o, mif.div_start_o, mif.div_annul_o,
                 mif.result_valid_o, mif.hilo_we_o}), 64'd0);
        @(negedge clk);
        #1;
        chk("rst held valid", 64'(mif.result_valid_o), 64'd0);
        rst = 1'b1;
        mif.op_signed_i = 1'b0;
        run_vec(vecs[0], 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 Parameter MUL_LAT, default 2, range 1..15: cycles from mul_start_o to a valid mul_result_i on the pipelined multiplier.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 op_mul_i  in  1  E-stage instruction is MULT/MULTU.
REQ-005 op_div_i  in  1  E-stage instruction is DIV/DIVU.
REQ-006 op_signed_i  in  1  1 = signed operation.
REQ-007 src_a_i, src_b_i  in  32 each  operands: dividend/multiplicand, divisor/multiplier.
REQ-008 stall_i  in  1  pipeline cannot advance E->M this cycle.
REQ-009 flush_i  in  1  kill the E-stage instruction.
REQ-010 mul_start_o  out  1  one-cycle start pulse to the multiplier.
REQ-011 mul_result_i  in  64  multiplier result {hi,lo}.
REQ-012 div_start_o  out  1  one-cycle start pulse to the iterative divider.
REQ-013 div_annul_o  out  1  one-cycle abort pulse to the divider.
REQ-014 div_ready_i  in  1  divider result valid, one cycle.
REQ-015 div_result_i  in  64  divider result {remainder,quotient}.
REQ-016 opa_o, opb_o, signed_o  out  32, 32, 1  operands and sign latched at accept, held until IDLE is re-entered.
REQ-017 stall_o  out  1  request pipeline stall while an op is pending.
REQ-018 result_o  out  64  captured {hi,lo}.
REQ-019 result_valid_o  out  1  result_o is valid.
REQ-020 hilo_we_o  out  1  HI/LO write enable.

Function
REQ-021 FSM states SHALL be IDLE, MUL_BUSY, DIV_BUSY, DONE.
REQ-022 IDLE, op_div_i=1, flush_i=0, src_b_i!=0 SHALL: latch the operands, pulse div_start_o, and go to DIV_BUSY.
REQ-023 IDLE, op_div_i=1, flush_i=0, src_b_i==0 SHALL: skip the divider, capture {src_a_i, 32'hFFFFFFFF}, and go to DONE.
REQ-024 IDLE, op_mul_i=1, op_div_i=0, flush_i=0 SHALL: latch the operands, pulse mul_start_o, load the counter with MUL_LAT-1, and go to MUL_BUSY.
REQ-025 When op_mul_i and op_div_i are both 1, the divide SHALL take priority.
REQ-026 MUL_BUSY SHALL decrement the counter each cycle; when count==0 it SHALL capture mul_result_i and go to DONE (MUL_LAT=2: accept at c0, capture at c2, DONE at c3).
REQ-027 DIV_BUSY SHALL stay in DIV_BUSY until div_ready_i; on div_ready_i it SHALL capture div_result_i and go to DONE the next cycle. There is no timeout.
REQ-028 stall_o SHALL be 1 in MUL_BUSY and DIV_BUSY, and in IDLE when (op_mul_i|op_div_i)&~flush_i; it SHALL be 0 otherwise, including in DONE.
REQ-029 DONE SHALL hold result_valid_o=1 and hilo_we_o=~stall_i. It SHALL go to IDLE when stall_i=0 and SHALL remain in DONE when stall_i=1.
REQ-030 HI/LO SHALL be written exactly once per accepted op.
REQ-031 After DONE->IDLE the next op SHALL be accepted in IDLE, giving one cycle minimum between accepts.
REQ-032 flush_i in MUL_BUSY or DONE SHALL return to IDLE without hilo_we_o.
REQ-033 flush_i in DIV_BUSY SHALL also pulse div_annul_o for one cycle.
REQ-034 flush_i SHALL take priority over div_ready_i, count==0 and stall_i arriving in the same cycle.
REQ-035 div_start_o, mul_start_o and div_annul_o SHALL never be high for more than one consecutive cycle.
REQ-036 result_o SHALL be cleared to 0 on entry to IDLE.

Reset
REQ-037 rst=0 SHALL immediately force IDLE, counter 0, opa_o/opb_o/result_o=0, signed_o/result_valid_o/hilo_we_o=0, and all start/annul pulses=0.
REQ-038 stall_o under reset SHALL follow REQ-028 for IDLE.
REQ-039 Reset during DIV_BUSY SHALL NOT pulse div_annul_o; the divider is reset by the same rst.
REQ-040 After rst deasserts, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-041 Signed DIV, src_a=-7, src_b=2, div_ready_i 33 cycles after start, div_result_i={32'hFFFFFFFF,32'hFFFFFFFD} -> stall_o=1 for 34 cycles, DONE with result_o={FFFFFFFF,FFFFFFFD}, single hilo_we_o.
REQ-042 MULTU, src_a=32'hFFFFFFFF, src_b=2, MUL_LAT=2, mul_result_i=64'h1_FFFFFFFE at c2 -> DONE at c3, hilo_we_o at c3, result_o=64'h00000001FFFFFFFE.
REQ-043 DIV with src_b=0, src_a=5 -> no div_start_o, DONE next cycle, result_o={32'h5,32'hFFFFFFFF}.
REQ-044 DONE with stall_i=1 for 3 cycles then 0 -> hilo_we_o=0 for 3 cycles, then 1 for exactly one cycle, then IDLE.
REQ-045 flush_i on cycle 10 of DIV_BUSY with div_ready_i also high -> div_annul_o pulse, IDLE, no hilo_we_o, result_valid_o=0.
REQ-046 rst=0 mid-MUL_BUSY -> all outputs 0 asynchronously, no start/annul pulses, next op accepted normally.
